// File: rtl/dp_mem_responder.sv
// Memory-side responder: arbitrates datapath I/D requests onto a single-port RAM.
// Optional access timeout with sticky mem_err is enabled by defining MEM_TIMEOUT_EN.
module dp_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              halt,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              halted,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, HALTED} state_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_store;
  logic                r_wr;
  logic                r_ihit;
  logic                r_dhit;
  logic [DATA_W-1:0]   r_iload;
  logic [DATA_W-1:0]   r_dload;
  logic                w_take_d;
  logic                w_take_i;
  logic                w_done;
  logic                w_in_acc;
  logic                w_ram_ok;
  logic                w_expire;

  assign w_in_acc = (r_state == IACC) || (r_state == DACC);
  assign w_ram_ok = (ramstate == RAM_ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;

  assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (w_in_acc && !w_ram_ok && (w_next == IDLE)) begin
        r_cnt     <= '0;
        r_mem_err <= 1'b1;
      end else if (w_in_acc && !w_ram_ok) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign mem_err = r_mem_err;
`else
  assign w_expire = 1'b0;
  assign mem_err  = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_take_d = 1'b0;
    w_take_i = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Requests are still held during the hit cycle, so they are not resampled then.
        if (halt) begin
          w_next = HALTED;
        end else if (!(r_ihit || r_dhit)) begin
          if (dWEN || dREN) begin
            w_next   = DACC;
            w_take_d = 1'b1;
          end else if (iREN) begin
            w_next   = IACC;
            w_take_i = 1'b1;
          end
        end
      end
      IACC, DACC: begin
        if (w_ram_ok) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_expire) begin
          w_next = IDLE;
        end
      end
      default: w_next = HALTED;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_store <= '0;
      r_wr    <= 1'b0;
      r_ihit  <= 1'b0;
      r_dhit  <= 1'b0;
      r_iload <= '0;
      r_dload <= '0;
    end else begin
      r_state <= w_next;
      r_ihit  <= w_done && (r_state == IACC);
      r_dhit  <= w_done && (r_state == DACC);
      if (w_done && (r_state == IACC)) begin
        r_iload <= ramload;
      end
      if (w_done && (r_state == DACC) && !r_wr) begin
        r_dload <= ramload;
      end
      if (w_take_d) begin
        r_addr <= daddr;
        r_wr   <= dWEN;
        if (dWEN) begin
          r_store <= dstore;
        end
      end else if (w_take_i) begin
        r_addr <= iaddr;
        r_wr   <= 1'b0;
      end
    end
  end

  assign ramREN   = (r_state == IACC) || ((r_state == DACC) && !r_wr);
  assign ramWEN   = (r_state == DACC) && r_wr;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign ihit     = r_ihit;
  assign dhit     = r_dhit;
  assign iload    = r_iload;
  assign dload    = r_dload;
  assign halted   = (r_state == HALTED);

endmodule

// File: tb/tb_dp_mem_responder.sv
// Scoreboard bench for dp_mem_responder: behavioural RAM, reference memory, random I/D traffic.
module tb_dp_mem_responder;

  logic        CLK;
  logic        RST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        halted, mem_err;

  int checks   = 0;
  int failures = 0;

  dp_mem_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .halt(halt),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .halted(halted), .mem_err(mem_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- memories and reference state ----------------
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_last_dload;
  logic [31:0] iq [$];
  logic [31:0] dq [$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h2401_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic out_any();
    return |{ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, halted, mem_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event unexpected or missing", name);
  endtask

  // ---------------- behavioural RAM ----------------
  bit ram_rand;
  int fix_L, fix_E;
  int ram_cnt, ram_L, ram_E;

  initial begin
    ramstate = 2'd0;
    ramload  = '0;
    ram_cnt  = 0;
    ram_L    = 0;
    ram_E    = 0;
    forever begin
      @(negedge CLK);
      if (RST || !(ramREN || ramWEN)) begin
        ramstate = 2'd0;
        ram_cnt  = 0;
        ramload  = $urandom;
      end else begin
        if (ram_cnt == 0) begin
          if (ram_rand) begin
            ram_L = $urandom_range(0, 3);
            ram_E = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
          end else begin
            ram_L = fix_L;
            ram_E = fix_E;
          end
        end
        if (ram_cnt < ram_L) begin
          ramstate = 2'd1;
          ramload  = $urandom;
        end else if (ram_cnt < ram_L + ram_E) begin
          ramstate = 2'd3;
          ramload  = $urandom;
        end else begin
          ramstate = 2'd2;
          if (ramWEN) ram_mem[ramaddr] = ramstore;
          else        ramload = ram_rd(ramaddr);
        end
        ram_cnt++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_hit;
    prev_hit = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (ihit && dhit) fail_now("both_hits");
        if (ihit) begin
          if (iq.size() == 0) fail_now("unexpected_ihit");
          else check("iload", iload, iq.pop_front());
        end
        if (dhit) begin
          if (dq.size() == 0) fail_now("unexpected_dhit");
          else check("dload", dload, dq.pop_front());
        end
        if (ihit || dhit) begin
          check("hit_gap", 32'(prev_hit), 32'd0);
          check("mem_err", 32'(mem_err), 32'd0);
        end
        if (ramREN || ramWEN) check("one_enable", 32'(ramREN & ramWEN), 32'd0);
      end
      prev_hit = ihit || dhit;
    end
  end

  // ---------------- requester tasks (called at a negedge) ----------------
  task automatic i_access(input logic [31:0] a);
    int w;
    iaddr = a;
    iREN  = 1'b1;
    iq.push_back(ref_rd(a));
    w = 0;
    do begin @(negedge CLK); w++; end while (!ihit && w < 3000);
    if (!ihit) fail_now("ihit_timeout");
    iREN = 1'b0;
  endtask

  task automatic d_access(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] d);
    int w;
    daddr  = a;
    dstore = d;
    dWEN   = wr;
    dREN   = !wr || both;
    if (wr) begin
      ref_mem[a] = d;
      dq.push_back(ref_last_dload);
    end else begin
      ref_last_dload = ref_rd(a);
      dq.push_back(ref_last_dload);
    end
    w = 0;
    do begin @(negedge CLK); w++; end while (!dhit && w < 3000);
    if (!dhit) fail_now("dhit_timeout");
    dWEN = 1'b0;
    dREN = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int ik, dk, nh;
    logic bad;
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_rand = 1'b0; fix_L = 0; fix_E = 0; ref_last_dload = '0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", 32'(out_any()), 32'd0);
    RST = 1'b0;

    // Reset in the middle of a BUSY write
    @(negedge CLK);
    fix_L = 20; daddr = 32'h120; dstore = 32'h1234_5678; dWEN = 1'b1;
    repeat (2) @(negedge CLK);
    check("t1_ramWEN_busy", 32'(ramWEN), 32'd1);
    #2 RST = 1'b1;
    #1 check("t1_async_reset", 32'(out_any()), 32'd0);
    dWEN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      bad = bad | dhit | ramWEN;
    end
    check("t1_after_reset", 32'(bad), 32'd0);

    // Instruction fetch with 3 BUSY cycles
    fix_L = 3; fix_E = 0;
    iaddr = 32'h40; iREN = 1'b1; iq.push_back(ref_rd(32'h40));
    ik = 0; nh = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        check("t2_ramREN", 32'(ramREN), 32'd1);
        check("t2_ramaddr", ramaddr, 32'h40);
        iaddr = $urandom;
      end
      if (k == 4) check("t2_ramaddr_held", ramaddr, 32'h40);
      if (ihit) begin
        nh++;
        if (ik == 0) ik = k;
        iREN = 1'b0;
      end
    end
    check("t2_ihit_cycle", ik, 5);
    check("t2_ihit_count", nh, 1);
    check("t2_iload", iload, 32'h2401_0005);

    // Simultaneous data and instruction reads, immediate ACCESS
    fix_L = 0; fix_E = 0;
    daddr = 32'h100; dREN = 1'b1; iaddr = 32'h4; iREN = 1'b1;
    ref_last_dload = ref_rd(32'h100);
    dq.push_back(ref_last_dload);
    iq.push_back(ref_rd(32'h4));
    ik = 0; dk = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k == 1) check("t3_ramaddr_data_first", ramaddr, 32'h100);
      if (dhit && dk == 0) begin dk = k; dREN = 1'b0; end
      if (ihit && ik == 0) begin ik = k; iREN = 1'b0; end
    end
    check("t3_dhit_cycle", dk, 2);
    check("t3_ihit_cycle", ik, 5);
    check("t3_dload", dload, init_word(32'h100));

    // Write wins over simultaneous read
    fix_L = 1;
    daddr = 32'h200; dstore = 32'hDEAD_BEEF; dWEN = 1'b1; dREN = 1'b1;
    ref_mem[32'h200] = 32'hDEAD_BEEF;
    dq.push_back(ref_last_dload);
    dk = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        check("t4_ramWEN", 32'(ramWEN), 32'd1);
        check("t4_ramREN", 32'(ramREN), 32'd0);
        check("t4_ramstore", ramstore, 32'hDEAD_BEEF);
        check("t4_ramaddr", ramaddr, 32'h200);
        daddr = $urandom; dstore = $urandom;
      end
      if (dhit && dk == 0) begin dk = k; dWEN = 1'b0; dREN = 1'b0; end
    end
    check("t4_dhit_cycle", dk, 3);
    check("t4_dload_unchanged", dload, init_word(32'h100));
    d_access(1'b0, 1'b0, 32'h200, 32'h0);
    check("t4_readback", dload, 32'hDEAD_BEEF);

    // Randomized concurrent traffic
    ram_rand = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 4)) @(negedge CLK);
          i_access($urandom_range(0, 63) << 2);
        end
      end
      begin
        for (int n = 0; n < 60; n++) begin
          int op;
          repeat ($urandom_range(0, 4)) @(negedge CLK);
          op = $urandom_range(0, 2);
          d_access(op != 0, op == 2, 32'h100 + ($urandom_range(0, 31) << 2), $urandom);
        end
      end
    join
    repeat (5) @(negedge CLK);
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);

    // ERROR twice then ACCESS, halt raised during the access
    ram_rand = 1'b0; fix_L = 0; fix_E = 2;
    daddr = 32'h104; dREN = 1'b1;
    ref_last_dload = ref_rd(32'h104);
    dq.push_back(ref_last_dload);
    dk = 0; nh = 0; bad = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 1) halt = 1'b1;
      if (k <= 3) bad = bad | !ramREN;
      if (dhit) begin
        nh++;
        if (dk == 0) dk = k;
        dREN = 1'b0;
      end
    end
    check("t5_ramREN_held", 32'(bad), 32'd0);
    check("t5_dhit_cycle", dk, 4);
    check("t5_dhit_count", nh, 1);
    check("t5_halted", 32'(halted), 32'd1);
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h108;
    bad = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      bad = bad | ramREN | ramWEN | ihit | dhit | !halted;
    end
    check("t5_halt_absorbing", 32'(bad), 32'd0);
    check("final_iq_empty", iq.size(), 0);
    check("final_dq_empty", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
